// File: rtl/fpnew_opgrp_scheduler.sv
// Operation-group scheduler: routes FPU requests to the four opgroup blocks,
// limits in-flight work per group and merges results round-robin.
module fpnew_opgrp_scheduler #(
  parameter int unsigned WIDTH           = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [3:0]         op_i,
  output logic [3:0]         opgrp_in_valid_o,
  input  logic [3:0]         opgrp_in_ready_i,
  input  logic [3:0]         opgrp_out_valid_i,
  output logic [3:0]         opgrp_out_ready_o,
  input  logic [4*WIDTH-1:0] opgrp_result_i,
  input  logic [4*5-1:0]     opgrp_status_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic [4:0]         status_o,
  output logic [1:0]         out_opgrp_o,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [1:0] {
    ADDMUL, DIVSQRT, NONCOMP, CONV
  } opgroup_e;

  function automatic opgroup_e get_opgroup(input logic [3:0] op);
    opgroup_e g;
    case (op)
      FMADD, FNMSUB, ADD, MUL:    g = ADDMUL;
      DIV, SQRT:                  g = DIVSQRT;
      F2F, F2I, I2F, CPKAB, CPKCD: g = CONV;
      default:                    g = NONCOMP;
    endcase
    return g;
  endfunction

  logic [CW-1:0] cnt_q [4];
  logic [1:0]    rr_q;
  logic          out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]    status_q;
  logic [1:0]    opgrp_q;

  logic [1:0] grp;
  logic [3:0] not_full;
  logic [3:0] active;
  logic       issue;
  logic [3:0] inc;
  logic [3:0] dec;
  logic       found;
  logic [1:0] win;
  logic       load_en;
  logic       res_hs;

  assign grp = get_opgroup(op_i);

  always_comb begin
    not_full = '0;
    active   = '0;
    for (int g = 0; g < 4; g++) begin
      not_full[g] = cnt_q[g] < CNT_MAX;
      active[g]   = cnt_q[g] != '0;
    end
  end

  // A full group blocks issue regardless of in_valid_i
  assign opgrp_in_valid_o =
    (in_valid_i && !flush_i && not_full[grp]) ?
    (4'b0001 << grp) : 4'b0000;
  assign in_ready_o = opgrp_in_valid_o[grp] && opgrp_in_ready_i[grp];
  assign issue      = in_valid_i && in_ready_o;
  assign inc        = issue ? (4'b0001 << grp) : 4'b0000;

  // Round-robin search starting at rr_q
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = rr_q;
    idx   = rr_q;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && opgrp_out_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign load_en           = !out_valid_q || out_ready_i;
  assign res_hs            = found && load_en && !flush_i;
  assign dec               = res_hs ? (4'b0001 << win) : 4'b0000;
  assign opgrp_out_ready_o = dec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int g = 0; g < 4; g++) cnt_q[g] <= '0;
    end else if (flush_i) begin
      for (int g = 0; g < 4; g++) cnt_q[g] <= '0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        if (inc[g] && !dec[g])
          cnt_q[g] <= cnt_q[g] + CW'(1);
        else if (dec[g] && !inc[g] && cnt_q[g] != '0)
          cnt_q[g] <= cnt_q[g] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      opgrp_q     <= '0;
    end else if (flush_i) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
    end else if (res_hs) begin
      rr_q        <= win + 2'd1;
      out_valid_q <= 1'b1;
      result_q    <= opgrp_result_i[win*WIDTH +: WIDTH];
      status_q    <= opgrp_status_i[win*5 +: 5];
      opgrp_q     <= win;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign status_o    = status_q;
  assign out_opgrp_o = opgrp_q;
  assign busy_o      = (|active) || out_valid_q;

endmodule

// File: tb/tb_fpnew_opgrp_scheduler.sv
// Bench for fpnew_opgrp_scheduler: directed scenarios plus random traffic
// compared cycle by cycle with a behavioural model.
module tb_fpnew_opgrp_scheduler;

  localparam int MAXO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [3:0]   iv;
  logic [3:0]   irdy;
  logic [3:0]   ov;
  logic [3:0]   ordy;
  logic [255:0] res;
  logic [19:0]  st;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  result;
  logic [4:0]   status;
  logic [1:0]   out_grp;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int          mcnt [4];
  int          mrr;
  bit          mov;
  logic [63:0] mres;
  logic [4:0]  mst;
  logic [1:0]  mgrp;

  fpnew_opgrp_scheduler #(.WIDTH(64), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
    .opgrp_in_valid_o(iv), .opgrp_in_ready_i(irdy),
    .opgrp_out_valid_i(ov), .opgrp_out_ready_o(ordy),
    .opgrp_result_i(res), .opgrp_status_i(st),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .status_o(status),
    .out_opgrp_o(out_grp), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int op2grp(input logic [3:0] o);
    if (o <= 4'd3) return 0;
    if (o <= 4'd5) return 1;
    if (o <= 4'd9) return 2;
    if (o <= 4'd14) return 3;
    return 2;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 4; g++) mcnt[g] = 0;
    mrr  = 0;
    mov  = 0;
    mres = '0;
    mst  = '0;
    mgrp = '0;
  endtask

  // Called just after a negedge with inputs already driven; returns at posedge.
  task automatic step();
    int g, w;
    bit found, ld, eir, eb, iss;
    logic [3:0] eiv, eor;
    g   = op2grp(op);
    eiv = (in_valid && !flush && mcnt[g] < MAXO) ? 4'(1 << g) : 4'b0;
    eir = eiv[g] && irdy[g];
    iss = in_valid && eir;
    ld  = !mov || out_ready;
    found = 0;
    w = 0;
    for (int k = 0; k < 4; k++)
      if (!found && ov[(mrr + k) % 4]) begin
        found = 1;
        w = (mrr + k) % 4;
      end
    eor = (found && ld && !flush) ? 4'(1 << w) : 4'b0;
    eb  = mov;
    for (int k = 0; k < 4; k++) if (mcnt[k] != 0) eb = 1;
    #1;
    check("in_valid_vec", 64'(iv), 64'(eiv));
    check("in_ready", 64'(in_ready), 64'(eir));
    check("out_ready_vec", 64'(ordy), 64'(eor));
    check("busy", 64'(busy), 64'(eb));
    check("out_valid", 64'(out_valid), 64'(mov));
    check("result", result, mres);
    check("status", 64'(status), 64'(mst));
    check("out_grp", 64'(out_grp), 64'(mgrp));
    if (flush) begin
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
      mrr = 0;
      mov = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        bit up, dn;
        up = iss && (g == k);
        dn = (eor[k] == 1'b1);
        if (up && !dn) mcnt[k]++;
        else if (dn && !up && mcnt[k] > 0) mcnt[k]--;
      end
      if (eor != 4'b0) begin
        mres = res[w*64 +: 64];
        mst  = st[w*5 +: 5];
        mgrp = 2'(w);
        mov  = 1;
        mrr  = (w + 1) % 4;
      end else if (out_ready) begin
        mov = 0;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    flush     = 0;
    in_valid  = 0;
    op        = 4'd0;
    irdy      = 4'b1111;
    ov        = 4'b0;
    out_ready = 1;
    for (int g = 0; g < 4; g++) begin
      res[g*64 +: 64] = 64'hA0 + 64'(g);
      st[g*5 +: 5]    = 5'(g + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #2;
    rst = 0;
    model_reset();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single ADD: issue, return result, drain
    @(negedge clk); in_valid = 1; op = 4'd2; step();
    @(negedge clk); in_valid = 0; ov = 4'b0001; step();
    @(negedge clk); ov = 4'b0; step();
    @(negedge clk); step();

    // Fill DIVSQRT, then a fifth attempt and result+issue cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1; op = 4'd4; step();
    end
    @(negedge clk); ov = 4'b0010; step();
    @(negedge clk); step();
    @(negedge clk); ov = 4'b0; step();
    @(negedge clk); in_valid = 0; ov = 4'b0010; step();
    @(negedge clk); ov = 4'b0; step();

    // Round-robin sweep across all groups
    @(negedge clk); flush = 1; step();
    @(negedge clk); flush = 0; ov = 4'b1111;
    repeat (5) begin step(); @(negedge clk); end
    ov = 4'b0; step();

    // Hold 0xDEAD under backpressure, then release
    @(negedge clk); res[0 +: 64] = 64'hDEAD; ov = 4'b0001; step();
    @(negedge clk); out_ready = 0; ov = 4'b0100;
    repeat (3) begin step(); @(negedge clk); end
    out_ready = 1; step();
    @(negedge clk); ov = 4'b0; step();

    // Undefined opcode routes to NONCOMP
    @(negedge clk); in_valid = 1; op = 4'd15; step();
    @(negedge clk); in_valid = 0; step();

    // Flush with everything active
    @(negedge clk); in_valid = 1; op = 4'd11; step();
    @(negedge clk); ov = 4'b1000; out_ready = 0; step();
    @(negedge clk); in_valid = 1; op = 4'd0; ov = 4'b1111;
    flush = 1; step();
    @(negedge clk); flush = 0; in_valid = 0; ov = 4'b0; out_ready = 1; step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 4'($urandom_range(0, 15));
      irdy      = 4'($urandom);
      ov        = 4'($urandom) & 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) < 3);
      for (int g = 0; g < 4; g++) begin
        res[g*64 +: 64] = {$urandom, $urandom};
        st[g*5 +: 5]    = 5'($urandom);
      end
      step();
    end

    // Asynchronous reset pulse between edges
    @(negedge clk); idle_inputs(); in_valid = 1; op = 4'd6; ov = 4'b0001;
    step();
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_grp", 64'(out_grp), 64'd0);
    rst = 0;
    model_reset();
    in_valid = 0;
    ov = 4'b0;
    @(negedge clk); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
